ysyx_22041752_inst_axi_bridge: RTL and testbench

YSYX_22041752_INST_AXI_BRIDGE -- requirements
Module: ysyx_22041752_inst_axi_bridge

---
 rtl/ysyx_22041752_inst_axi_bridge_pkg.sv | 20 ++
 rtl/ysyx_22041752_inst_axi_bridge.sv | 97 +++++++++
 tb/tb_ysyx_22041752_inst_axi_bridge.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041752_inst_axi_bridge_pkg.sv
// Shared widths and state encoding for the instruction-fetch AXI4-Lite bridge.
//   SRAM_ADDR_WD : fetch request address width
//   SRAM_DATA_WD : AXI data bus and inst_rdata width
//   INST_WD      : instruction width, carried in inst_rdata[INST_WD-1:0]
package ysyx_22041752_inst_axi_bridge_pkg;

  localparam int SRAM_ADDR_WD = 32;
  localparam int SRAM_DATA_WD = 64;
  localparam int INST_WD      = 32;

  localparam logic [2:0] AXI_ARPROT_INST = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/ysyx_22041752_inst_axi_bridge.sv
// Instruction-fetch bridge: turns a single fetch request into one AXI4-Lite
// read and returns the instruction as a one-cycle response pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no read in flight, ready for a fetch request
// AR    | read address presented, waiting for arready
// R     | address accepted, waiting for rvalid
// RESP  | response pulse; may accept the next request in the same cycle
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   inst_en, inst_addr         fetch request
//   inst_ready                 request can be accepted this cycle
//   inst_valid, inst_rdata,    response pulse, instruction in
//   inst_err                   inst_rdata[INST_WD-1:0], error flag
//   araddr/arvalid/arready/    AXI4-Lite read address channel
//   arprot
//   rdata/rresp/rvalid/rready  AXI4-Lite read data channel
module ysyx_22041752_inst_axi_bridge
  import ysyx_22041752_inst_axi_bridge_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inst_en,
  input  logic [SRAM_ADDR_WD-1:0] inst_addr,
  output logic                    inst_ready,
  output logic                    inst_valid,
  output logic [SRAM_DATA_WD-1:0] inst_rdata,
  output logic                    inst_err,
  output logic [31:0]             araddr,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [2:0]              arprot,
  input  logic [63:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  bridge_state_e           state_q, state_d;
  logic [SRAM_ADDR_WD-1:0] addr_q;
  logic [SRAM_DATA_WD-1:0] data_q;
  logic                    err_q;
  logic                    accept;
  logic                    r_hs;
  logic                    unused_addr_bits;

  // Reset feeds inst_ready directly so no request is seen while reset is high.
  assign inst_ready = ~reset & ((state_q == ST_IDLE) | (state_q == ST_RESP));
  assign accept     = inst_en & inst_ready;
  assign r_hs       = rvalid & rready;

  // Outputs decode straight from the state register so an async reset clears
  // them immediately.
  assign arvalid    = (state_q == ST_AR);
  assign rready     = (state_q == ST_R);
  assign inst_valid = (state_q == ST_RESP);
  assign inst_err   = (state_q == ST_RESP) & err_q;
  assign inst_rdata = data_q;
  assign araddr     = {addr_q[31:3], 3'b000};
  assign arprot     = AXI_ARPROT_INST;

  // Byte offset within the word is irrelevant to a doubleword-aligned read.
  assign unused_addr_bits = ^addr_q[1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)  state_d = ST_AR;
      ST_AR:   if (arready) state_d = ST_R;
      ST_R:    if (rvalid)  state_d = ST_RESP;
      ST_RESP: state_d = accept ? ST_AR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        addr_q <= inst_addr;
      // data_q is only rewritten by the next read, so the fetch stage may
      // sample it any time after the response pulse.
      if (r_hs) begin
        data_q <= addr_q[2] ? {32'b0, rdata[63:32]} : rdata;
        err_q  <= (rresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_inst_axi_bridge.sv
module tb_ysyx_22041752_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_valid;
  logic [63:0] inst_rdata;
  logic        inst_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [63:0] RD_A = 64'h1111_2222_0000_0013;
  localparam logic [63:0] RD_B = 64'hAAAA_BBBB_CCCC_DDDD;

  ysyx_22041752_inst_axi_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready),
    .inst_valid (inst_valid),
    .inst_rdata (inst_rdata),
    .inst_err   (inst_err),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .arprot     (arprot),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch from IDLE. Caller is positioned 1 time unit after a clock edge.
  task automatic do_fetch(input logic [31:0] a, input logic [1:0] resp,
                          input int ar_wait, input int r_wait,
                          input logic [31:0] a_late, input logic [63:0] exp_data,
                          input logic exp_err);
    inst_en   = 1'b1;
    inst_addr = a;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rresp     = resp;
    rdata     = RD_A;
    chk("idle_ready", inst_ready, 1'b1);
    step();
    // AR: request may keep being asserted with a new address; must be ignored
    inst_addr = a_late;
    inst_en   = (ar_wait > 0);
    for (int i = 0; i < ar_wait; i++) begin
      chk("ar_stall_arvalid", arvalid, 1'b1);
      chk("ar_stall_araddr", araddr, {a[31:3], 3'b000});
      chk("ar_stall_ready", inst_ready, 1'b0);
      step();
    end
    inst_en = 1'b0;
    arready = 1'b1;
    chk("ar_arvalid", arvalid, 1'b1);
    chk("ar_araddr", araddr, {a[31:3], 3'b000});
    chk("ar_arprot", arprot, 3'b100);
    chk("ar_rready", rready, 1'b0);
    step();
    arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      chk("r_stall_rready", rready, 1'b1);
      chk("r_stall_ready", inst_ready, 1'b0);
      chk("r_stall_valid", inst_valid, 1'b0);
      step();
    end
    rvalid = 1'b1;
    chk("r_rready", rready, 1'b1);
    chk("r_arvalid", arvalid, 1'b0);
    step();
    rvalid = 1'b0;
    rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    rresp  = 2'b00;
    chk("resp_valid", inst_valid, 1'b1);
    chk("resp_rdata", inst_rdata, exp_data);
    chk("resp_err", inst_err, exp_err);
    chk("resp_ready", inst_ready, 1'b1);
    step();
    chk("after_valid", inst_valid, 1'b0);
    chk("after_arvalid", arvalid, 1'b0);
    chk("after_rdata_hold", inst_rdata, exp_data);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [63:0] rd;
    logic [63:0] exp;
  } b2b_t;

  initial begin
    b2b_t tbl[3];
    tbl[0] = '{32'h8000_0000, RD_A, RD_A};
    tbl[1] = '{32'h8000_0004, RD_A, 64'h0000_0000_1111_2222};
    tbl[2] = '{32'h8000_0008, RD_B, RD_B};

    reset = 1'b1; inst_en = 1'b0; inst_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    #12;
    chk("rst_ready", inst_ready, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_rdata", inst_rdata, 64'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_err", inst_err, 1'b0);
    inst_en = 1'b1;
    step();
    chk("rst_en_ignored", arvalid, 1'b0);
    inst_en = 1'b0;
    reset = 1'b0;
    step();

    // single aligned fetch, minimum latency
    do_fetch(32'h8000_0000, 2'b00, 0, 0, 32'h8000_0000, RD_A, 1'b0);
    // upper-word fetch
    do_fetch(32'h8000_0004, 2'b00, 0, 0, 32'h8000_0004, 64'h0000_0000_1111_2222, 1'b0);
    // slave stalls, inst_en held while busy must not queue a request
    do_fetch(32'h8000_0010, 2'b00, 5, 3, 32'h9000_0000, RD_A, 1'b0);
    // error response plus address change after acceptance
    do_fetch(32'h8000_0104, 2'b10, 0, 0, 32'h8000_0200, 64'h0000_0000_1111_2222, 1'b1);

    // back-to-back with a zero-wait slave
    inst_en   = 1'b1;
    inst_addr = tbl[0].a;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("b2b_arvalid", arvalid, 1'b1);
      chk("b2b_araddr", araddr, {tbl[k].a[31:3], 3'b000});
      chk("b2b_valid_ar", inst_valid, 1'b0);
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = tbl[k].rd;
      chk("b2b_rready", rready, 1'b1);
      step();
      rvalid = 1'b0;
      chk("b2b_valid", inst_valid, 1'b1);
      chk("b2b_rdata", inst_rdata, tbl[k].exp);
      if (k < 2) inst_addr = tbl[k + 1].a;
      else inst_en = 1'b0;
    end
    step();
    chk("b2b_end_arvalid", arvalid, 1'b0);
    chk("b2b_end_valid", inst_valid, 1'b0);
    chk("b2b_end_hold", inst_rdata, RD_B);

    // reset while in R
    inst_en = 1'b1; inst_addr = 32'h8000_0004;
    step();
    inst_en = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rr_in_r", rready, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rr_rready", rready, 1'b0);
    chk("rr_valid", inst_valid, 1'b0);
    chk("rr_ready_in_rst", inst_ready, 1'b0);
    chk("rr_rdata", inst_rdata, 64'h0);
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    #3 reset = 1'b0;
    step();
    chk("rr_ready_after", inst_ready, 1'b1);
    chk("rr_arvalid_after", arvalid, 1'b0);
    chk("rr_valid_after", inst_valid, 1'b0);
    step();
    chk("rr_idle_stays", inst_valid, 1'b0);

    // normal fetch after reset recovery
    do_fetch(32'h8000_0000, 2'b00, 0, 0, 32'h8000_0000, RD_A, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
